pc_address_generator: RTL and testbench
=======================================

# pc_address_generator

Program-counter and fetch-address stage for the 32-word instruction/data memory path. It holds an 8-bit program counter and advances it by increment, signed relative branch or absolute jump. It issues each address to memory through a request/acknowledge handshake and presents it on `Address8bits`, which the downstream 8-to-5 address compressor truncates to the 5-bit memory address. It also flags addresses the 5-bit memory cannot reach and reports fetches that are never acknowledged.

## Interface
Parameters:
- `RESET_ADDR`, 8'h00: program-counter value loaded on reset.
- `MEM_ADDR_BITS`, 5: address bits the downstream memory decodes; sets the `OutOfRange` threshold.
- `MAX_WAIT`, 15: cycles spent in REQ without `FetchAck` before `FetchErr` pulses. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Stall`  in  1  holds the current instruction; blocks PC advance while high.
- `Jump`  in  1  take `JumpTarget` on the next advance.
- `JumpTarget`  in  8  absolute target address.
- `BranchTaken`  in  1  take the relative branch on the next advance.
- `BranchOffset`  in  8  signed two's-complement offset, relative to the current PC.
- `FetchAck`  in  1  memory has accepted the current address.
- `FetchReq`  out  1  fetch request; high while in REQ.
- `Address8bits`  out  8  current PC, registered; feeds the compressor.
- `InstrValid`  out  1  high while the fetched word at `Address8bits` is valid (VALID state).
- `OutOfRange`  out  1  high when `Address8bits >= 2**MEM_ADDR_BITS`; decoded from the PC register, no added latency.
- `FetchErr`  out  1  one-cycle pulse when the fetch wait reaches `MAX_WAIT`.

## Operation
- Reset (`rst_n` low, any time, asynchronous): PC = `RESET_ADDR`, state IDLE, wait counter = 0. `FetchReq`, `InstrValid` and `FetchErr` are 0. `OutOfRange` follows the reset PC (0 for the default). Reset during REQ or VALID abandons the fetch immediately, with no completion.
- States and transitions:
  - IDLE: always goes to REQ on the next edge. Entered only from reset.
  - REQ: `FetchReq`=1. The PC is held stable and every cycle increments the wait counter.
    - `FetchAck`=1 at an edge: go to VALID and clear the counter.
    - Counter reaches `MAX_WAIT` with no ack: pulse `FetchErr` for one cycle, clear the counter, stay in REQ and retry the same address.
    - Ack in the same cycle the counter would expire: the ack wins and there is no `FetchErr`.
  - VALID: `InstrValid`=1.
    - `Stall`=1: stay in VALID with the PC unchanged.
    - `Stall`=0: load the next PC and go to REQ.
- Next-PC priority (sampled only in VALID with `Stall`=0):
  1. `Jump`: PC = `JumpTarget`.
  2. `BranchTaken`: PC = PC + sign-extended `BranchOffset`.
  3. Otherwise: PC = PC + 1.
  - `Jump` wins when `Jump` and `BranchTaken` are both high.
  - `Jump`, `BranchTaken` and their operands are ignored in IDLE, REQ, or VALID with `Stall`=1. They are not latched for later use.
- Arithmetic: all PC math is modulo 256. 8'hFF + 1 = 8'h00. 8'h02 + 8'hFC (−4) = 8'hFE. There is no overflow flag.
- `OutOfRange` is informational only: the block still issues the address, and the downstream compressor aliases it.
- `FetchAck` outside REQ is ignored.

## Timing
- First fetch after reset release: IDLE in cycle 0, REQ (`FetchReq`=1) in cycle 1. With `FetchAck` high in cycle 1, VALID (`InstrValid`=1) in cycle 2.
- Minimum steady-state rate is one instruction per 2 cycles (REQ, then VALID), with an immediate ack and no stall.
- The new `Address8bits` appears in the same cycle that `FetchReq` rises. `Address8bits` is constant throughout REQ and VALID.
- `InstrValid` drops in the cycle after a non-stalled VALID cycle.
- `FetchErr` is high in the cycle after the MAX_WAIT-th consecutive un-acked REQ cycle, and pulses again every `MAX_WAIT` cycles while the ack stays absent.
- All outputs are registered or decoded directly from registers, so there is no combinational path from any input to any output.

## Test plan
- Reset/increment: `rst_n` low then released, `FetchAck` tied high → `Address8bits` runs 0,0,1,1,2,… with `InstrValid` alternating 0/1. All outputs are 0 during reset.
- Branch/jump priority: at PC=8'h10 in VALID, `BranchTaken`=1 with offset 8'hF8 → next PC 8'h08. At PC=8'h08, `Jump`=1 with target 8'h40 and `BranchTaken`=1 at the same time → next PC 8'h40 and `OutOfRange`=1.
- Wrap-around: jump to 8'hFF, then increment → 8'h00 and `OutOfRange` drops. At PC 8'h01, a branch of 8'h7F → 8'h80.
- Stall: hold `Stall`=1 for 5 cycles in VALID → PC frozen, `InstrValid` stays 1, and `Jump` pulses during the stall are ignored. Releasing `Stall` → PC+1.
- Handshake timeout: `FetchAck`=0 with `MAX_WAIT`=3 → `FetchErr` pulses every 3 cycles with the PC unchanged. An ack on the expiry cycle gives no pulse and a transition to VALID.
- Async reset mid-fetch: `rst_n` low while in REQ at PC 8'h25 → `FetchReq` and `InstrValid` go to 0 and the PC goes to `RESET_ADDR` before the next clock edge.

Source files
------------

// File: rtl/pc_address_generator.sv
// pc_address_generator: 8-bit program counter with request/ack fetch handshake,
// relative branch / absolute jump, out-of-range flag and fetch-timeout pulse.
module pc_address_generator #(
    parameter logic [7:0] RESET_ADDR    = 8'h00,
    parameter int         MEM_ADDR_BITS = 5,
    parameter int         MAX_WAIT      = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Stall,
    input  logic       Jump,
    input  logic [7:0] JumpTarget,
    input  logic       BranchTaken,
    input  logic [7:0] BranchOffset,
    input  logic       FetchAck,
    output logic       FetchReq,
    output logic [7:0] Address8bits,
    output logic       InstrValid,
    output logic       OutOfRange,
    output logic       FetchErr
);
    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt, cnt, cnt_nxt;
    logic       err, err_nxt;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = 8'd0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // an ack on the expiry cycle takes priority over the timeout
                if (FetchAck)
                    state_nxt = VALID;
                else if (cnt + 8'd1 == WAIT_LIMIT)
                    err_nxt = 1'b1;
                else
                    cnt_nxt = cnt + 8'd1;
            end
            VALID: begin
                if (!Stall) begin
                    state_nxt = REQ;
                    pc_nxt    = Jump ? JumpTarget : BranchTaken ? pc + BranchOffset : pc + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_ADDR;
            cnt   <= 8'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    assign FetchReq     = (state == REQ);
    assign InstrValid   = (state == VALID);
    assign Address8bits = pc;
    assign OutOfRange   = (pc >> MEM_ADDR_BITS) != 8'd0;
    assign FetchErr     = err;
endmodule

// File: tb/tb_pc_address_generator.sv
// tb_pc_address_generator: directed and random checks of the PC/fetch stage
// against a cycle-level behavioural model of fetch phases and PC arithmetic.
module tb_pc_address_generator;
    localparam int MW = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Stall, Jump, BranchTaken, FetchAck;
    logic [7:0] JumpTarget, BranchOffset;
    logic       FetchReq, InstrValid, OutOfRange, FetchErr;
    logic [7:0] Address8bits;

    int errors = 0;
    int checks = 0;

    // model: phase 0 = idle, 1 = waiting for ack, 2 = word valid
    int m_ph, m_pc, m_wait;
    bit m_err;

    pc_address_generator #(.RESET_ADDR(8'h00), .MEM_ADDR_BITS(5), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .FetchAck(FetchAck),
        .FetchReq(FetchReq), .Address8bits(Address8bits), .InstrValid(InstrValid),
        .OutOfRange(OutOfRange), .FetchErr(FetchErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_pc = 0; m_wait = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, Address8bits, 8'(m_pc));
        chk({tag, ".req"}, {7'd0, FetchReq}, {7'd0, m_ph == 1});
        chk({tag, ".valid"}, {7'd0, InstrValid}, {7'd0, m_ph == 2});
        chk({tag, ".oor"}, {7'd0, OutOfRange}, {7'd0, m_pc >= 32});
        chk({tag, ".err"}, {7'd0, FetchErr}, {7'd0, m_err});
    endtask

    task automatic step(input string tag, input logic s, input logic j, input logic [7:0] t,
                        input logic b, input logic [7:0] o, input logic a);
        int soff;
        Stall = s; Jump = j; JumpTarget = t; BranchTaken = b; BranchOffset = o; FetchAck = a;
        @(posedge clk);
        m_err = 0;
        if (m_ph == 0) m_ph = 1;
        else if (m_ph == 1) begin
            if (a) begin m_ph = 2; m_wait = 0; end
            else begin
                m_wait++;
                if (m_wait == MW) begin m_err = 1; m_wait = 0; end
            end
        end else if (!s) begin
            soff = (o >= 128) ? int'(o) - 256 : int'(o);
            m_pc = j ? int'(t) : b ? (m_pc + soff + 256) % 256 : (m_pc + 1) % 256;
            m_ph = 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic inc(input string tag);
        step(tag, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        {Stall, Jump, BranchTaken, FetchAck} = '0;
        JumpTarget = 8'h00; BranchOffset = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all("idle");

        // increment run with ack tied high: 0,0,1,1,2,...
        for (int i = 0; i < 6; i++) inc("incr");
        chk("incr.pc2", Address8bits, 8'h02);
        while (!(m_ph == 2 && m_pc == 16)) inc("walk");

        step("branch", 1'b0, 1'b0, 8'h00, 1'b1, 8'hF8, 1'b1);
        chk("branch.pc", Address8bits, 8'h08);
        inc("ack");
        step("jmp_pri", 1'b0, 1'b1, 8'h40, 1'b1, 8'h05, 1'b1);
        chk("jmp_pri.pc", Address8bits, 8'h40);
        chk("jmp_pri.oor", {7'd0, OutOfRange}, 8'h01);
        inc("ack");

        step("to_ff", 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
        inc("ack");
        inc("wrap");
        chk("wrap.pc", Address8bits, 8'h00);
        chk("wrap.oor", {7'd0, OutOfRange}, 8'h00);
        inc("ack");
        inc("to_01");
        inc("ack");
        step("br7f", 1'b0, 1'b0, 8'h00, 1'b1, 8'h7F, 1'b1);
        chk("br7f.pc", Address8bits, 8'h80);
        inc("ack");

        for (int i = 0; i < 5; i++)
            step("stall", 1'b1, 1'b1, 8'(i * 7), i[0], 8'h10, 1'b1);
        chk("stall.valid", {7'd0, InstrValid}, 8'h01);
        inc("unstall");
        chk("unstall.pc", Address8bits, 8'h81);

        for (int i = 0; i < 6; i++) step("tmo", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("tmo.err2", {7'd0, FetchErr}, 8'h01);
        chk("tmo.pc", Address8bits, 8'h81);
        step("tmo", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step("tmo", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        inc("ackwin");
        chk("ackwin.err", {7'd0, FetchErr}, 8'h00);
        chk("ackwin.valid", {7'd0, InstrValid}, 8'h01);

        step("to_25", 1'b0, 1'b1, 8'h25, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async");
        chk("async.pc", Address8bits, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(3) == 0), ($urandom_range(3) == 0), 8'($urandom),
                 ($urandom_range(2) == 0), 8'($urandom), ($urandom_range(2) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
